// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load/store, range/legality checks it, issues a single
// data-memory op and returns the result. Optional alignment trap: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DMEM_BYTES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        rsp_cause,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_op,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] OpNop = 3'b111;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [1:0]          rsp_cause_q, rsp_cause_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [2:0]          mem_op_q, mem_op_d;
  logic                mem_wr_q, mem_wr_d;
  logic                is_load_q, is_load_d;

  logic        illegal, misaligned, fault;
  logic [2:0]  size_m1;
  logic [32:0] last_byte;
  logic [2:0]  op_map;

  // Request decode, only meaningful while IDLE
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_m1 = 3'd0;
      2'b01:   size_m1 = 3'd1;
      default: size_m1 = 3'd3;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap back into range
    last_byte = {1'b0, req_addr} + {30'b0, size_m1};
    fault     = last_byte >= 33'(DMEM_BYTES);

    if (req_we) illegal = req_funct3 >= 3'b011;
    else        illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);

`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif

    // Unsigned loads are packed after the signed ones in the memory's MemOp encoding
    if (req_we) begin
      op_map = req_funct3;
    end else begin
      case (req_funct3)
        3'b100:  op_map = 3'b011;
        3'b101:  op_map = 3'b100;
        default: op_map = req_funct3;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_cause_d = rsp_cause_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_op_d    = mem_op_q;
    mem_wr_d    = mem_wr_q;
    is_load_d   = is_load_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          rsp_rdata_d = 32'h0;
          is_load_d   = !req_we;
          if (illegal || misaligned || fault) begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            if (illegal)         rsp_cause_d = 2'b11;
            else if (misaligned) rsp_cause_d = 2'b01;
            else                 rsp_cause_d = 2'b10;
            state_d = StResp;
          end else begin
            mem_addr_d  = req_addr[ADDR_W-1:0];
            mem_wdata_d = req_wdata;
            mem_op_d    = op_map;
            mem_wr_d    = req_we;
            state_d     = StIssue;
          end
        end
      end
      StIssue: begin
        mem_op_d = OpNop;
        mem_wr_d = 1'b0;
        if (is_load_q) begin
          state_d = StCapture;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StCapture: begin
        rsp_rdata_d = mem_rdata;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_cause_d = 2'b00;
          req_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_cause_q <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_op_q    <= OpNop;
      mem_wr_q    <= 1'b0;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_cause_q <= rsp_cause_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_op_q    <= mem_op_d;
      mem_wr_q    <= mem_wr_d;
      is_load_q   <= is_load_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_cause = rsp_cause_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_op    = mem_op_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-wise little-endian data memory model
// and a response scoreboard.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DMEM_BYTES = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [1:0]        rsp_cause;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_op;
  logic              mem_wr;
  logic [31:0]       mem_rdata = 32'h0;

  load_store_unit #(.ADDR_W(ADDR_W), .DMEM_BYTES(DMEM_BYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_cause (rsp_cause),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_op    (mem_op),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: performs the op present at a rising edge, DataOut registered
  logic [7:0]  dmem [DMEM_BYTES] = '{default: 8'h00};
  logic [10:0] a0, a1, a2, a3;
  assign a0 = mem_addr[10:0];
  assign a1 = a0 + 11'd1;
  assign a2 = a0 + 11'd2;
  assign a3 = a0 + 11'd3;

  always @(posedge clk) begin
    if (mem_wr) begin
      case (mem_op)
        3'b000: dmem[a0] <= mem_wdata[7:0];
        3'b001: begin dmem[a0] <= mem_wdata[7:0]; dmem[a1] <= mem_wdata[15:8]; end
        3'b010: begin
          dmem[a0] <= mem_wdata[7:0];   dmem[a1] <= mem_wdata[15:8];
          dmem[a2] <= mem_wdata[23:16]; dmem[a3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end else begin
      case (mem_op)
        3'b000: mem_rdata <= {{24{dmem[a0][7]}}, dmem[a0]};
        3'b001: mem_rdata <= {{16{dmem[a1][7]}}, dmem[a1], dmem[a0]};
        3'b010: mem_rdata <= {dmem[a3], dmem[a2], dmem[a1], dmem[a0]};
        3'b011: mem_rdata <= {24'h0, dmem[a0]};
        3'b100: mem_rdata <= {16'h0, dmem[a1], dmem[a0]};
        default: ;
      endcase
    end
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request/response; exp_op 4'b0111 means no memory op may be issued
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int lat, input logic [31:0] exp_rdata,
                     input logic exp_err, input logic [1:0] exp_cause, input logic [3:0] exp_op,
                     input int hold);
    exp_t e;
    int   n;
    sb.push_back('{rdata: exp_rdata, err: exp_err, cause: exp_cause});
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    chk("issue_op", 32'({mem_wr, mem_op}), 32'(exp_op));
    if (exp_op != 4'b0111) begin
      chk("issue_addr", 32'(mem_addr), 32'(addr[ADDR_W-1:0]));
      if (we) chk("issue_wdata", mem_wdata, wdata);
    end
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
      chk("nop_after_issue", 32'({mem_wr, mem_op}), 32'h7);
    end
    chk("latency", 32'(n), 32'(lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, sb[0].rdata);
      chk("hold_cause", 32'({rsp_err, rsp_cause}), 32'({sb[0].err, sb[0].cause}));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_nop", 32'({mem_wr, mem_op}), 32'h7);
    end
    e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
    chk("rsp_cause", 32'(rsp_cause), 32'(e.cause));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_clr", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_cause}), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_op", 32'({mem_wr, mem_op}), 32'h7);

    // Word store then load
    txn(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 2'b00, 4'b1010, 0);
    txn(1'b0, 3'b010, 32'h010, 32'h0, 3, 32'hDEADBEEF, 1'b0, 2'b00, 4'b0010, 0);
    // Byte: signed and unsigned
    txn(1'b1, 3'b000, 32'h020, 32'h000000F0, 2, 32'h0, 1'b0, 2'b00, 4'b1000, 0);
    txn(1'b0, 3'b000, 32'h020, 32'h0, 3, 32'hFFFFFFF0, 1'b0, 2'b00, 4'b0000, 0);
    txn(1'b0, 3'b100, 32'h020, 32'h0, 3, 32'h000000F0, 1'b0, 2'b00, 4'b0011, 0);
    // Halfword, with a stalled response consumer
    txn(1'b1, 3'b001, 32'h030, 32'h00008001, 2, 32'h0, 1'b0, 2'b00, 4'b1001, 0);
    txn(1'b0, 3'b001, 32'h030, 32'h0, 3, 32'hFFFF8001, 1'b0, 2'b00, 4'b0001, 0);
    txn(1'b0, 3'b101, 32'h030, 32'h0, 3, 32'h00008001, 1'b0, 2'b00, 4'b0100, 5);
    // Range edges
    txn(1'b0, 3'b010, 32'h7FC, 32'h0, 3, 32'h0, 1'b0, 2'b00, 4'b0010, 0);
    txn(1'b1, 3'b000, 32'h7FF, 32'h0000007F, 2, 32'h0, 1'b0, 2'b00, 4'b1000, 0);
    txn(1'b0, 3'b000, 32'h7FF, 32'h0, 3, 32'h0000007F, 1'b0, 2'b00, 4'b0000, 0);
    txn(1'b0, 3'b000, 32'h800, 32'h0, 1, 32'h0, 1'b1, 2'b10, 4'b0111, 0);
    txn(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1, 1, 32'h0, 1'b1, 2'b10, 4'b0111, 3);
    // Illegal funct3, including priority over access fault
    txn(1'b0, 3'b110, 32'h010, 32'h0, 1, 32'h0, 1'b1, 2'b11, 4'b0111, 0);
    txn(1'b1, 3'b011, 32'h010, 32'h0, 1, 32'h0, 1'b1, 2'b11, 4'b0111, 0);
    txn(1'b0, 3'b111, 32'h7FF, 32'h0, 1, 32'h0, 1'b1, 2'b11, 4'b0111, 0);
    // Unaligned accesses
    txn(1'b1, 3'b010, 32'h040, 32'h44332211, 2, 32'h0, 1'b0, 2'b00, 4'b1010, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    txn(1'b0, 3'b001, 32'h041, 32'h0, 1, 32'h0, 1'b1, 2'b01, 4'b0111, 0);
    txn(1'b0, 3'b010, 32'h7FE, 32'h0, 1, 32'h0, 1'b1, 2'b01, 4'b0111, 0);
`else
    txn(1'b0, 3'b001, 32'h041, 32'h0, 3, 32'h00003322, 1'b0, 2'b00, 4'b0001, 0);
    txn(1'b0, 3'b010, 32'h7FE, 32'h0, 1, 32'h0, 1'b1, 2'b10, 4'b0111, 0);
`endif
    // Verify no store hit memory from the faulted SW above
    txn(1'b0, 3'b010, 32'h010, 32'h0, 3, 32'hDEADBEEF, 1'b0, 2'b00, 4'b0010, 0);

    // Reset during CAPTURE
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp", 32'({rsp_valid, rsp_err, rsp_cause}), 32'h0);
    chk("midrst_rdata", rsp_rdata, 32'h0);
    chk("midrst_mem", 32'({mem_wr, mem_op}), 32'h7);
    chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst_idle", 32'({req_ready, rsp_valid}), 32'h2);
    txn(1'b0, 3'b100, 32'h020, 32'h0, 3, 32'h000000F0, 1'b0, 2'b00, 4'b0011, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
